// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory controller.
//   - access size encodings (SZ_*)
//   - FSM state enum
//   - captured request struct
//   - lane_be(): byte-enable mask for a store of a given size at a given
//     byte offset within the word
package data_mem_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } dm_state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sign_ext;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dm_req_t;

    // Half accesses are naturally aligned, so only addr[1] picks the lane pair.
    function automatic logic [NUM_LANES-1:0] lane_be(input logic [1:0] sz,
                                                      input logic [1:0] lo);
        case (sz)
            SZ_BYTE: return 4'b0001 << lo;
            SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dm_byte_ram.sv
// Byte-lane word memory.
//   clk    : write clock
//   we     : write strobe, qualified per lane by be
//   be     : per-lane byte enable
//   waddr  : write word index
//   wdata  : write data, lane n in [8n+7:8n]
//   raddr  : read word index (asynchronous read)
//   rdata  : read data
// The storage has no reset; it is zeroed only by the controller's fill.
module dm_byte_ram
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [NUM_LANES-1:0]        be,
    input  logic [AW-1:0]               waddr,
    input  logic [NUM_LANES*LANE_W-1:0] wdata,
    input  logic [AW-1:0]               raddr,
    output logic [NUM_LANES*LANE_W-1:0] rdata
);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [LANE_W-1:0] mem [DEPTH_WORDS];

        always_ff @(posedge clk) begin
            if (we && be[g]) begin
                mem[waddr] <= wdata[g*LANE_W +: LANE_W];
            end
        end

        assign rdata[g*LANE_W +: LANE_W] = mem[raddr];
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: byte/half/word loads and stores against a
// DEPTH_WORDS x 32-bit byte-lane memory, with optional zero fill after reset
// and a fixed number of wait cycles before each response.
//   clk      : clock
//   reset    : asynchronous active-low reset
//   req      : request valid, held with its fields until ack
//   we       : 1 store, 0 load
//   size     : 00 byte, 01 half, 10 word, 11 illegal
//   sign_ext : load extension select (byte/half loads only)
//   addr     : byte address, little-endian lanes
//   wdata    : store data, right-justified
//   ack      : one-cycle completion pulse
//   rdata    : load result in the ack cycle, 0 otherwise
//   err      : misaligned / out-of-range / illegal size, in the ack cycle
//   busy     : zero fill in progress
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS    = 256,
    parameter int WAIT_CYCLES    = 0,
    parameter bit CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int             AW          = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0]  LAST_IDX    = AW'(DEPTH_WORDS - 1);
    localparam logic [3:0]     WAIT_LAST   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam dm_state_t      RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    dm_state_t     state;
    logic [AW-1:0] clr_cnt;
    logic [3:0]    wait_cnt;
    dm_req_t       cap;
    dm_req_t       live;
    dm_req_t       cur;

    always_comb begin
        live.we       = we;
        live.size     = size;
        live.sign_ext = sign_ext;
        live.addr     = addr;
        live.wdata    = wdata;
    end

    // With no wait cycles the response is computed in the acceptance cycle,
    // before the request has been captured, so decode from the live inputs
    // while idle and from the captured copy afterwards.
    assign cur = (state == ST_IDLE) ? live : cap;

    // ---------------- decode ----------------
    logic          misalign;
    logic          oor;
    logic          bad_size;
    logic          dec_err;
    logic [AW-1:0] idx;

    always_comb begin
        misalign = ((cur.size == SZ_HALF) && cur.addr[0]) ||
                   ((cur.size == SZ_WORD) && (cur.addr[1:0] != 2'b00));
        bad_size = (cur.size == SZ_ILL);
        oor      = ({2'b00, cur.addr[31:2]} >= 32'(DEPTH_WORDS));
        dec_err  = misalign || bad_size || oor;
        idx      = cur.addr[AW+1:2];
    end

    // ---------------- memory ----------------
    logic                 ram_we;
    logic [NUM_LANES-1:0] ram_be;
    logic [AW-1:0]        ram_waddr;
    logic [31:0]          ram_wdata;
    logic [31:0]          ram_rdata;

    dm_byte_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .be   (ram_be),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(idx),
        .rdata(ram_rdata)
    );

    // Store data replicated across lanes; the byte enable picks the lane(s).
    logic [31:0] st_data;

    always_comb begin
        case (cur.size)
            SZ_BYTE: st_data = {4{cur.wdata[7:0]}};
            SZ_HALF: st_data = {2{cur.wdata[15:0]}};
            default: st_data = cur.wdata;
        endcase
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_be    = '0;
        ram_waddr = clr_cnt;
        ram_wdata = '0;
        if (state == ST_CLEAR) begin
            ram_we = 1'b1;
            ram_be = '1;
        end else if ((state == ST_RESP) && cap.we && !dec_err) begin
            ram_we    = 1'b1;
            ram_be    = lane_be(cap.size, cap.addr[1:0]);
            ram_waddr = idx;
            ram_wdata = st_data;
        end
    end

    // ---------------- load formatting ----------------
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_val;

    always_comb begin
        ld_b = ram_rdata[{cur.addr[1:0], 3'b000} +: 8];
        ld_h = cur.addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (cur.size)
            SZ_BYTE: ld_val = {{24{cur.sign_ext & ld_b[7]}}, ld_b};
            SZ_HALF: ld_val = {{16{cur.sign_ext & ld_h[15]}}, ld_h};
            default: ld_val = ram_rdata;
        endcase
        if (dec_err || cur.we) begin
            ld_val = '0;
        end
    end

    // ---------------- control ----------------
    // ack/rdata/err are loaded on the edge entering RESP so they are valid
    // for exactly the RESP cycle; the store itself lands on the edge leaving it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RESET_STATE;
            clr_cnt  <= '0;
            wait_cnt <= '0;
            cap      <= '0;
            ack      <= 1'b0;
            rdata    <= '0;
            err      <= 1'b0;
        end else begin
            ack   <= 1'b0;
            rdata <= '0;
            err   <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_IDX) begin
                        clr_cnt <= '0;
                        state   <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (req) begin
                        cap      <= live;
                        wait_cnt <= '0;
                        if (WAIT_CYCLES > 0) begin
                            state <= ST_WAIT;
                        end else begin
                            state <= ST_RESP;
                            ack   <= 1'b1;
                            rdata <= ld_val;
                            err   <= dec_err;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= ST_RESP;
                        ack   <= 1'b1;
                        rdata <= ld_val;
                        err   <= dec_err;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= RESET_STATE;
            endcase
        end
    end

    assign busy = (state == ST_CLEAR);

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        ack0, err0, busy0, ack1, err1, busy1;
    logic [31:0] rdata0, rdata1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_ctrl #(.DEPTH_WORDS(16), .WAIT_CYCLES(2), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .reset(reset), .req(req0), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
    );

    data_mem_ctrl #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .CLEAR_ON_RESET(0)) dut_b (
        .clk(clk), .reset(reset), .req(req1), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .ack(ack1), .rdata(rdata1), .err(err1), .busy(busy1)
    );

    typedef struct {
        string       name;
        logic        w;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void add(input string n, input logic w, input logic [1:0] sz,
                                input logic sx, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] e, input logic ee);
        vec_t v;
        v.name = n; v.w = w; v.sz = sz; v.sx = sx; v.a = a; v.d = d;
        v.exp_rd = e; v.exp_err = ee;
        vecs.push_back(v);
    endfunction

    // Entered just after a rising edge; returns just after a rising edge.
    // lat = number of cycles from acceptance to the ack cycle (-1 on timeout).
    task automatic txn(input bit sel, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat);
        we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
        if (sel) req1 = 1'b1; else req0 = 1'b1;
        lat = -1; rd = '0; er = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (sel ? ack1 : ack0) begin
                lat = n;
                rd  = sel ? rdata1 : rdata0;
                er  = sel ? err1 : err0;
                break;
            end
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          nbusy;
        int          nack;
        int          t0, t1;

        // ---------------- reset state ----------------
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ack_a",   32'(ack0),  32'd0);
        chk("rst_rdata_a", rdata0,     32'd0);
        chk("rst_err_a",   32'(err0),  32'd0);
        chk("rst_busy_a",  32'(busy0), 32'd1);
        chk("rst_busy_b",  32'(busy1), 32'd0);

        // ---------------- fill: req held high must not be taken ----------------
        @(posedge clk); #1;
        reset = 1'b1;
        we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h3C; wdata = '0;
        req0 = 1'b1;
        nbusy = 0; nack = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!busy0) break;
            nbusy++;
            if (ack0) nack++;
        end
        chk("clear_busy_cycles", 32'(nbusy), 32'd16);
        chk("clear_no_ack",      32'(nack),  32'd0);
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            if (ack0) begin lat = n; rd = rdata0; er = err0; break; end
            @(negedge clk);
        end
        chk("first_load_lat", 32'(lat), 32'd3);
        chk("first_load_rd",  rd,       32'h0);
        chk("first_load_err", 32'(er),  32'd0);
        @(posedge clk); #1; req0 = 1'b0;
        chk("busy_after_clear", 32'(busy0), 32'd0);

        // ---------------- table-driven vectors on dut_a ----------------
        add("st_w_10",      1, 2'b10, 0, 32'h10, 32'h8899AABB, 32'h0,        0);
        add("st_b_11",      1, 2'b00, 0, 32'h11, 32'h0000007F, 32'h0,        0);
        add("ld_w_10",      0, 2'b10, 0, 32'h10, 32'h0,        32'h88997FBB, 0);
        add("st_w_20",      1, 2'b10, 0, 32'h20, 32'h0000F080, 32'h0,        0);
        add("ld_b_20_sx",   0, 2'b00, 1, 32'h20, 32'h0,        32'hFFFFFF80, 0);
        add("ld_h_20_zx",   0, 2'b01, 0, 32'h20, 32'h0,        32'h0000F080, 0);
        add("ld_h_20_sx",   0, 2'b01, 1, 32'h20, 32'h0,        32'hFFFFF080, 0);
        add("ld_b_21_sx",   0, 2'b00, 1, 32'h21, 32'h0,        32'hFFFFFFF0, 0);
        add("ld_b_11_sx",   0, 2'b00, 1, 32'h11, 32'h0,        32'h0000007F, 0);
        add("st_w_oor_40",  1, 2'b10, 0, 32'h40, 32'h12345678, 32'h0,        1);
        add("ld_w_00",      0, 2'b10, 0, 32'h00, 32'h0,        32'h0,        0);
        add("ld_h_mis_13",  0, 2'b01, 0, 32'h13, 32'h0,        32'h0,        1);
        add("ld_ill_10",    0, 2'b11, 0, 32'h10, 32'h0,        32'h0,        1);
        add("st_h_12",      1, 2'b01, 0, 32'h12, 32'h1234CAFE, 32'h0,        0);
        add("ld_w_10_b",    0, 2'b10, 0, 32'h10, 32'h0,        32'hCAFE7FBB, 0);
        add("ld_h_12_zx",   0, 2'b01, 0, 32'h12, 32'h0,        32'h0000CAFE, 0);
        add("ld_b_13_zx",   0, 2'b00, 0, 32'h13, 32'h0,        32'h000000CA, 0);
        add("ld_b_13_sx",   0, 2'b00, 1, 32'h13, 32'h0,        32'hFFFFFFCA, 0);
        add("st_w_mis_22",  1, 2'b10, 0, 32'h22, 32'hFFFFFFFF, 32'h0,        1);
        add("ld_w_20",      0, 2'b10, 0, 32'h20, 32'h0,        32'h0000F080, 0);
        add("st_w_3c",      1, 2'b10, 0, 32'h3C, 32'h80000001, 32'h0,        0);
        add("st_b_3d",      1, 2'b00, 0, 32'h3D, 32'hAAAAAA55, 32'h0,        0);
        add("ld_w_3c_sx",   0, 2'b10, 1, 32'h3C, 32'h0,        32'h80005501, 0);
        add("ld_w_mis_3e",  0, 2'b10, 0, 32'h3E, 32'h0,        32'h0,        1);
        add("ld_b_oor_40",  0, 2'b00, 0, 32'h40, 32'h0,        32'h0,        1);
        add("ld_w_oor_hi",  0, 2'b10, 0, 32'h80000010, 32'h0,  32'h0,        1);

        foreach (vecs[i]) begin
            txn(1'b0, vecs[i].w, vecs[i].sz, vecs[i].sx, vecs[i].a, vecs[i].d, rd, er, lat);
            chk({vecs[i].name, "_rd"},  rd,       vecs[i].exp_rd);
            chk({vecs[i].name, "_err"}, 32'(er),  32'(vecs[i].exp_err));
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'd3);
        end

        // ---------------- reset during WAIT abandons the store ----------------
        we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h04; wdata = 32'hDEADBEEF;
        req0 = 1'b1;
        @(negedge clk);             // acceptance cycle
        @(negedge clk);             // first WAIT cycle
        reset = 1'b0;
        nack = 0;
        repeat (2) begin
            @(negedge clk);
            if (ack0) nack++;
        end
        req0 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        nbusy = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ack0) nack++;
            if (!busy0) break;
            nbusy++;
        end
        chk("rstwait_no_ack",      32'(nack),  32'd0);
        chk("rstwait_busy_cycles", 32'(nbusy), 32'd16);
        @(posedge clk); #1;
        txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, rd, er, lat);
        chk("rstwait_ld_04", rd, 32'h0);
        txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("refill_ld_10", rd, 32'h0);

        // ---------------- back-to-back stores with req held ----------------
        we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h08; wdata = 32'h11111111;
        req0 = 1'b1;
        t0 = -1; t1 = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ack0) begin
                if (t0 < 0) begin
                    t0 = cyc;
                    addr = 32'h0C; wdata = 32'h22222222;
                end else begin
                    t1 = cyc;
                    break;
                end
            end
        end
        @(posedge clk); #1; req0 = 1'b0;
        chk("b2b_spacing", 32'(t1 - t0), 32'd4);
        txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, rd, er, lat);
        chk("b2b_ld_08", rd, 32'h11111111);
        txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, rd, er, lat);
        chk("b2b_ld_0c", rd, 32'h22222222);

        // ---------------- zero-wait, no-fill instance ----------------
        chk("b_busy_idle", 32'(busy1), 32'd0);
        txn(1'b1, 1'b1, 2'b10, 1'b0, 32'h08, 32'hA5A5A5A5, rd, er, lat);
        chk("b_st_lat", 32'(lat), 32'd1);
        chk("b_st_rd",  rd,       32'h0);
        txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, rd, er, lat);
        chk("b_ld_lat", 32'(lat), 32'd1);
        chk("b_ld_w",   rd,       32'hA5A5A5A5);
        txn(1'b1, 1'b0, 2'b00, 1'b1, 32'h0B, 32'h0, rd, er, lat);
        chk("b_ld_b_sx", rd, 32'hFFFFFFA5);
        txn(1'b1, 1'b0, 2'b01, 1'b0, 32'h09, 32'h0, rd, er, lat);
        chk("b_ld_h_mis_err", 32'(er), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
